// File: rtl/seq_alu_if.sv
// Request/result bundle between the control unit and seq_alu.
//
// Handshake: a request transfers on a rising edge where in_valid and in_ready
// are both 1; a result transfers on a rising edge where out_valid and
// out_ready are both 1. A valid side holds its payload stable until the
// transfer edge. in_ready may depend combinationally on out_ready, never on
// in_valid.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_z;
  logic             flag_c;
  logic             flag_v;
  logic             err;

  modport master (
    output in_valid, opcode, a, b, out_ready,
    input  in_ready, out_valid, result, flag_z, flag_c, flag_v, err
  );

  modport slave (
    input  in_valid, opcode, a, b, out_ready,
    output in_ready, out_valid, result, flag_z, flag_c, flag_v, err
  );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: registered, handshaked ALU for the register-read -> writeback path.
// Opcodes 0-15 finish one cycle after acceptance. Opcodes 16-19 (MUL, MULHU,
// DIVU, REMU) use an iterative radix-2 datapath, built only when the macro
// SEQ_ALU_MULDIV_EN is defined; otherwise they are reported as illegal.
// dbg_state exposes the IDLE/BUSY/DONE state for checkers.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  seq_alu_if.slave   bus,
  output logic [1:0] dbg_state
);
  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_AND   = 5'd2;
  localparam logic [4:0] OP_OR    = 5'd3;
  localparam logic [4:0] OP_XOR   = 5'd4;
  localparam logic [4:0] OP_NOR   = 5'd5;
  localparam logic [4:0] OP_NOT   = 5'd6;
  localparam logic [4:0] OP_SLL   = 5'd7;
  localparam logic [4:0] OP_SRL   = 5'd8;
  localparam logic [4:0] OP_SRA   = 5'd9;
  localparam logic [4:0] OP_INC   = 5'd10;
  localparam logic [4:0] OP_DEC   = 5'd11;
  localparam logic [4:0] OP_SLT   = 5'd12;
  localparam logic [4:0] OP_SGT   = 5'd13;
  localparam logic [4:0] OP_LUI   = 5'd14;
  localparam logic [4:0] OP_POP   = 5'd15;
`ifdef SEQ_ALU_MULDIV_EN
  localparam logic [4:0] OP_MUL   = 5'd16;
  localparam logic [4:0] OP_MULHU = 5'd17;
  localparam logic [4:0] OP_DIVU  = 5'd18;
  localparam logic [4:0] OP_REMU  = 5'd19;
`endif

  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  logic   accept;

  assign dbg_state = state;

  // A new request fits when idle, or when the held result leaves this cycle.
  assign bus.in_ready = (state == IDLE) || ((state == DONE) && bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   dif_w;
  logic [SHW:0]     pop_cnt;

  assign shamt = bus.b[SHW-1:0];

  // One shared adder/subtractor; INC and DEC substitute a constant 1 for b.
  always_comb begin
    addend = ((bus.opcode == OP_INC) || (bus.opcode == OP_DEC)) ? ONE_W : bus.b;
    sum_w  = {1'b0, bus.a} + {1'b0, addend};
    dif_w  = {1'b0, bus.a} - {1'b0, addend};
  end

  // Population count of operand a.
  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop_cnt = pop_cnt + {{SHW{1'b0}}, bus.a[i]};
    end
  end

  logic [WIDTH-1:0] sc_res;
  logic             sc_c;
  logic             sc_v;
  logic             sc_err;
`ifdef SEQ_ALU_MULDIV_EN
  logic             go_busy;
`endif

  // Result and flags for everything that completes one cycle after acceptance.
  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    sc_err = 1'b0;
`ifdef SEQ_ALU_MULDIV_EN
    go_busy = 1'b0;
`endif
    case (bus.opcode)
      OP_ADD, OP_INC: begin
        sc_res = sum_w[WIDTH-1:0];
        sc_c   = sum_w[WIDTH];
        sc_v   = (bus.a[MSB] == addend[MSB]) && (sum_w[MSB] != bus.a[MSB]);
      end
      OP_SUB, OP_DEC: begin
        sc_res = dif_w[WIDTH-1:0];
        sc_c   = dif_w[WIDTH];
        sc_v   = (bus.a[MSB] != addend[MSB]) && (dif_w[MSB] != bus.a[MSB]);
      end
      OP_AND: sc_res = bus.a & bus.b;
      OP_OR:  sc_res = bus.a | bus.b;
      OP_XOR: sc_res = bus.a ^ bus.b;
      OP_NOR: sc_res = ~(bus.a | bus.b);
      OP_NOT: sc_res = ~bus.a;
      OP_SLL: sc_res = bus.a << shamt;
      OP_SRL: sc_res = bus.a >> shamt;
      OP_SRA: sc_res = $signed(bus.a) >>> shamt;
      OP_SLT: begin
        sc_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
        sc_c   = dif_w[WIDTH];
      end
      OP_SGT: begin
        sc_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) > $signed(bus.b))};
        sc_c   = dif_w[WIDTH];
      end
      OP_LUI: sc_res = {bus.b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_POP: sc_res = {{(WIDTH-SHW-1){1'b0}}, pop_cnt};
`ifdef SEQ_ALU_MULDIV_EN
      OP_MUL, OP_MULHU: go_busy = 1'b1;
      OP_DIVU, OP_REMU: begin
        if (bus.b == '0) begin
          // Divide by zero skips iteration: quotient all ones, remainder a.
          sc_res = (bus.opcode == OP_DIVU) ? {WIDTH{1'b1}} : bus.a;
          sc_err = 1'b1;
        end else begin
          go_busy = 1'b1;
        end
      end
`endif
      default: sc_err = 1'b1;
    endcase
  end

`ifdef SEQ_ALU_MULDIV_EN
  localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_ONE  = {{SHW{1'b0}}, 1'b1};

  // acc = {high, low}: multiply keeps {partial product, multiplier};
  // divide keeps {partial remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   mcand;
  logic [SHW:0]       cnt;
  logic [1:0]         mop;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     div_trial;
  logic [WIDTH-1:0]   md_res;

  // One radix-2 step: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
    rem_sh    = acc[2*WIDTH-1:WIDTH-1];
    div_trial = rem_sh - {1'b0, mcand};
    if (!mop[1]) begin
      if (acc[0]) acc_nxt = {mul_sum, acc[WIDTH-1:1]};
      else        acc_nxt = {1'b0, acc[2*WIDTH-1:1]};
    end else begin
      if (!div_trial[WIDTH]) acc_nxt = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else                   acc_nxt = {acc[2*WIDTH-2:0], 1'b0};
    end
    case (mop)
      2'd0:    md_res = acc_nxt[WIDTH-1:0];
      2'd1:    md_res = acc_nxt[2*WIDTH-1:WIDTH];
      2'd2:    md_res = acc_nxt[WIDTH-1:0];
      default: md_res = acc_nxt[2*WIDTH-1:WIDTH];
    endcase
  end
`endif

  // Control FSM with registered result, flags and out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.flag_z    <= 1'b0;
      bus.flag_c    <= 1'b0;
      bus.flag_v    <= 1'b0;
      bus.err       <= 1'b0;
`ifdef SEQ_ALU_MULDIV_EN
      acc           <= '0;
      mcand         <= '0;
      cnt           <= '0;
      mop           <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
`ifdef SEQ_ALU_MULDIV_EN
            if (go_busy) begin
              state         <= BUSY;
              bus.out_valid <= 1'b0;
              acc           <= {{WIDTH{1'b0}}, bus.a};
              mcand         <= bus.b;
              cnt           <= CNT_INIT;
              mop           <= bus.opcode[1:0];
            end else
`endif
            begin
              state         <= DONE;
              bus.out_valid <= 1'b1;
              bus.result    <= sc_res;
              bus.flag_z    <= (sc_res == '0);
              bus.flag_c    <= sc_c;
              bus.flag_v    <= sc_v;
              bus.err       <= sc_err;
            end
          end else if ((state == DONE) && bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
          end
        end
        BUSY: begin
`ifdef SEQ_ALU_MULDIV_EN
          acc <= acc_nxt;
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state         <= DONE;
            bus.out_valid <= 1'b1;
            bus.result    <= md_res;
            bus.flag_z    <= (md_res == '0);
            bus.flag_c    <= 1'b0;
            bus.flag_v    <= 1'b0;
            bus.err       <= 1'b0;
          end
`else
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu (WIDTH=32): directed vector table, hand-written hold,
// back-to-back and reset sequences, then random operations against a
// plain-arithmetic reference model. Follows SEQ_ALU_MULDIV_EN like the RTL.
module tb_seq_alu;
  localparam int W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Scoreboard entries: {err, v, c, z, result}.
  logic [W+3:0] exp_q[$];

  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
    logic         c;
    logic         v;
    logic         err;
    logic [7:0]   lat;
  } exp_t;

  typedef struct {
    string      name;
    logic [4:0] op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic       z;
    logic       c;
    logic       v;
    logic       err;
    int         lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic void add_vec(input string n, input logic [4:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b, input logic [W-1:0] res, input logic z,
                                  input logic c, input logic v, input logic err, input int lat);
    vec_t t;
    t.name = n; t.op = op; t.a = a; t.b = b; t.res = res;
    t.z = z; t.c = c; t.v = v; t.err = err; t.lat = lat;
    vecs.push_back(t);
  endfunction

  // Reference model: results straight from the operation definitions.
  function automatic exp_t ref_model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t r;
    longint unsigned ua, ub, full;
    longint sa, sb, s;
    logic signed [W-1:0] as32;
    logic [63:0] prod;
    int sh, cnt;
    bit multi;
    r = '0;
    multi = 0;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b); as32 = a; sh = b[4:0];
    if (op == 5'd10 || op == 5'd11) begin ub = 1; sb = 1; end
    case (op)
      5'd0, 5'd10: begin
        full = ua + ub; r.res = full[W-1:0]; r.c = full[W];
        s = sa + sb; r.v = (s > SMAX) || (s < SMIN);
      end
      5'd1, 5'd11: begin
        full = ua - ub; r.res = full[W-1:0]; r.c = (ua < ub);
        s = sa - sb; r.v = (s > SMAX) || (s < SMIN);
      end
      5'd2: r.res = a & b;
      5'd3: r.res = a | b;
      5'd4: r.res = a ^ b;
      5'd5: r.res = ~(a | b);
      5'd6: r.res = ~a;
      5'd7: r.res = a << sh;
      5'd8: r.res = a >> sh;
      5'd9: r.res = as32 >>> sh;
      5'd12: begin r.res = (sa < sb) ? 1 : 0; r.c = (ua < ub); end
      5'd13: begin r.res = (sa > sb) ? 1 : 0; r.c = (ua < ub); end
      5'd14: r.res = ua[15:0] * 0 + (ub[15:0] * 64'd65536);
      5'd15: begin
        cnt = 0;
        for (int i = 0; i < W; i++) cnt += int'(a[i]);
        r.res = cnt;
      end
`ifdef SEQ_ALU_MULDIV_EN
      5'd16: begin prod = ua * ub; r.res = prod[W-1:0]; multi = 1; end
      5'd17: begin prod = ua * ub; r.res = prod[63:32]; multi = 1; end
      5'd18: if (ub == 0) begin r.res = '1; r.err = 1; end
             else begin r.res = ua / ub; multi = 1; end
      5'd19: if (ub == 0) begin r.res = a; r.err = 1; end
             else begin r.res = ua % ub; multi = 1; end
`endif
      default: r.err = 1;
    endcase
    r.z = (r.res == 0);
    r.lat = multi ? 8'(W + 1) : 8'd1;
    return r;
  endfunction

  // Driver: present a request at a negedge and hold it until accepted.
  task automatic issue(input logic [4:0] op, input logic [W-1:0] a_v, input logic [W-1:0] b_v);
    int guard;
    bus.in_valid = 1'b1; bus.opcode = op; bus.a = a_v; bus.b = b_v;
    #1;
    guard = 0;
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk); #1; guard++;
    end
    check("in_ready_wait", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Issue one op, wait for out_valid, compare latency and payload.
  task automatic run_op(input string name, input logic [4:0] op, input logic [W-1:0] a_v,
                        input logic [W-1:0] b_v, input logic [W-1:0] res, input logic z,
                        input logic c, input logic v, input logic err, input int exp_lat);
    int lat;
    logic [W+3:0] want;
    logic [W+3:0] got;
    exp_q.push_back({err, v, c, z, res});
    issue(op, a_v, b_v);
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(negedge clk); lat++;
    end
    check({name, ".lat"}, 64'(lat), 64'(exp_lat));
    want = exp_q.pop_front();
    got  = {bus.err, bus.flag_v, bus.flag_c, bus.flag_z, bus.result};
    check({name, ".res"}, 64'(got[W-1:0]), 64'(want[W-1:0]));
    check({name, ".flags_evcz"}, 64'(got[W+3:W]), 64'(want[W+3:W]));
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return W'($urandom_range(0, 40));
      default: return W'($urandom);
    endcase
  endfunction

  // Watchdog: the run must never hang.
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    logic [4:0] op;
    logic [W-1:0] ra, rb;
    int seen;

    // Directed vector table.
    add_vec("add_wrap",  5'd0,  32'hFFFF_FFFF, 32'h1,         32'h0,         1, 1, 0, 0, 1);
    add_vec("sub_ovf",   5'd1,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1, 1, 0, 1);
    add_vec("sra_31",    5'd9,  32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 0, 0, 0, 0, 1);
    add_vec("pop",       5'd15, 32'hF0F0_0001, 32'h0,         32'd9,         0, 0, 0, 0, 1);
    add_vec("sll_zero",  5'd7,  32'h1234_5678, 32'h0,         32'h1234_5678, 0, 0, 0, 0, 1);
    add_vec("inc_ovf",   5'd10, 32'h7FFF_FFFF, 32'h0,         32'h8000_0000, 0, 0, 1, 0, 1);
    add_vec("dec_zero",  5'd11, 32'h0,         32'h0,         32'hFFFF_FFFF, 0, 1, 0, 0, 1);
    add_vec("slt_neg",   5'd12, 32'hFFFF_FFFF, 32'h1,         32'h1,         0, 0, 0, 0, 1);
    add_vec("sgt",       5'd13, 32'd5,         32'd3,         32'h1,         0, 0, 0, 0, 1);
    add_vec("nor",       5'd5,  32'h0,         32'h0,         32'hFFFF_FFFF, 0, 0, 0, 0, 1);
    add_vec("lui",       5'd14, 32'h0,         32'h0000_ABCD, 32'hABCD_0000, 0, 0, 0, 0, 1);
    add_vec("illegal25", 5'd25, 32'h5,         32'h6,         32'h0,         1, 0, 0, 1, 1);
`ifdef SEQ_ALU_MULDIV_EN
    add_vec("mul",       5'd16, 32'h0001_0000, 32'h0001_0000, 32'h0,         1, 0, 0, 0, 33);
    add_vec("mulhu",     5'd17, 32'h0001_0000, 32'h0001_0000, 32'h1,         0, 0, 0, 0, 33);
    add_vec("divu",      5'd18, 32'd100,       32'd7,         32'd14,        0, 0, 0, 0, 33);
    add_vec("remu",      5'd19, 32'd100,       32'd7,         32'd2,         0, 0, 0, 0, 33);
    add_vec("divu_zero", 5'd18, 32'd100,       32'd0,         32'hFFFF_FFFF, 0, 0, 0, 1, 1);
    add_vec("remu_zero", 5'd19, 32'd100,       32'd0,         32'd100,       0, 0, 0, 1, 1);
`else
    add_vec("op16_ill",  5'd16, 32'h0001_0000, 32'h0001_0000, 32'h0,         1, 0, 0, 1, 1);
`endif

    bus.in_valid = 1'b0; bus.opcode = '0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state.
    check("rst.out_valid", 64'(bus.out_valid), 64'd0);
    check("rst.result",    64'(bus.result),    64'd0);
    check("rst.flags_evcz", 64'({bus.err, bus.flag_v, bus.flag_c, bus.flag_z}), 64'd0);
    check("rst.in_ready",  64'(bus.in_ready),  64'd1);
    check("rst.state",     64'(dbg_state),     64'd0);

    // Table.
    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
             vecs[i].z, vecs[i].c, vecs[i].v, vecs[i].err, vecs[i].lat);
    end

    // Hold a result with out_ready low, then hand over back-to-back.
    @(negedge clk);
    bus.out_ready = 1'b0;
    issue(5'd0, 32'd5, 32'd6);
    for (int i = 0; i < 5; i++) begin
      check("hold.out_valid", 64'(bus.out_valid), 64'd1);
      check("hold.result",    64'(bus.result),    64'd11);
      check("hold.in_ready",  64'(bus.in_ready),  64'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.opcode = 5'd14; bus.a = '0; bus.b = 32'h0000_ABCD;
    #1;
    check("b2b.in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("b2b.out_valid", 64'(bus.out_valid), 64'd1);
    check("b2b.result",    64'(bus.result),    64'hABCD_0000);
    @(negedge clk);
    check("b2b.drain", 64'(bus.out_valid), 64'd0);

    // Reset in the middle of a multiply.
    issue(5'd16, 32'h0001_0000, 32'h0001_0000);
    repeat (3) @(negedge clk);
`ifdef SEQ_ALU_MULDIV_EN
    check("busy.in_ready", 64'(bus.in_ready), 64'd0);
    check("busy.state",    64'(dbg_state),    64'd1);
`endif
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst.out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst.result",    64'(bus.result),    64'd0);
    check("midrst.flags_evcz", 64'({bus.err, bus.flag_v, bus.flag_c, bus.flag_z}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst.in_ready", 64'(bus.in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < W + 5; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("midrst.stale_valid", 64'(seen), 64'd0);

    // Random operations against the reference model.
    for (int n = 0; n < 300; n++) begin
      op = 5'($urandom_range(0, 31));
      ra = pick_operand();
      rb = pick_operand();
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (!bus.out_ready) begin
        @(negedge clk);
        bus.out_ready = 1'b1;
      end
      e = ref_model(op, ra, rb);
      run_op($sformatf("rand%0d_op%0d", n, op), op, ra, rb, e.res, e.z, e.c, e.v, e.err, int'(e.lat));
    end

    check("scoreboard.empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
